// File: rtl/pingpong_buf_pkg.sv
// Shared helpers for the ping-pong tile buffer: slice extraction, width sizing, ring pointers.
// Latency: pure functions, no state.
// Backpressure: not applicable.
package pingpong_buf_pkg;

  // Widest producer word the slice helper can handle; wider words are truncated from the top.
  localparam int MAX_W = 4096;

  // Return the MSB-first slice idx of an in_w-bit word, right-aligned; callers keep the low mod_w bits.
  function automatic logic [MAX_W-1:0] extract_slice(input logic [MAX_W-1:0] word,
                                                     input int in_w,
                                                     input int mod_w,
                                                     input int idx);
    return word >> (in_w - (idx + 1) * mod_w);
  endfunction

  // Bank pointer width; a single-bit pointer is kept even for two banks.
  function automatic int bank_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Occupancy counter width: must represent 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Modulo-n increment for ring pointers whose n need not be a power of two.
  function automatic logic [31:0] ring_inc(input logic [31:0] p, input int n);
    return (p == 32'(n - 1)) ? 32'd0 : p + 32'd1;
  endfunction

endpackage

// File: rtl/pp_sdp_ram.sv
// Simple dual-port RAM, one write and one read port, read-first.
// Latency: rdata is registered, valid one cycle after re; holds when re is low.
// Backpressure: none, accepts a write and a read every cycle.
module pp_sdp_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; a same-address write in the same cycle returns the old contents.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pingpong_tile_buffer.sv
// N-bank tile ring buffer between producer projection outputs and a random-access consumer.
// Latency: read data one cycle after rd_en; a completed tile is readable the cycle after its last beat.
// Backpressure: wr_ready drops while every bank is full; beats offered then are dropped and flagged sticky.
module pingpong_tile_buffer
  import pingpong_buf_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int CHUNK_SIZE    = 4,
  parameter int NUM_CORES_A   = 2,
  parameter int NUM_CORES_B   = 1,
  parameter int TOTAL_MODULES = 4,
  parameter int SLICE_IDX     = 0,
  parameter int NUM_INPUTS    = 2,
  parameter int NUM_BANKS     = 2,
  parameter int COL_X         = 256,
  localparam int MODULE_WIDTH = WIDTH * CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B,
  localparam int IN_WIDTH     = MODULE_WIDTH * TOTAL_MODULES,
  localparam int SEL_W        = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int IDX_W        = $clog2(COL_X),
  localparam int BANK_W       = bank_w(NUM_BANKS),
  localparam int CNT_W        = cnt_w(NUM_BANKS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [IN_WIDTH-1:0]     wr_data [NUM_INPUTS],
  input  logic                    rd_en,
  input  logic [SEL_W-1:0]        rd_sel,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [MODULE_WIDTH-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    rd_avail,
  input  logic                    rd_release,
  output logic [CNT_W-1:0]        full_count,
  output logic [BANK_W-1:0]       wr_bank,
  output logic [BANK_W-1:0]       rd_bank,
  output logic                    tile_done,
  output logic                    overflow_err
);

  localparam int DEPTH = NUM_BANKS * COL_X;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDX_W-1:0]        wr_idx;
  logic                    wr_fire;
  logic                    tile_cmp;
  logic                    rel;
  logic                    re;
  logic [AW-1:0]           waddr;
  logic [AW-1:0]           raddr;
  logic [SEL_W-1:0]        sel_q;
  logic                    have_read;
  logic [MODULE_WIDTH-1:0] ram_q [NUM_INPUTS];
  logic [MODULE_WIDTH-1:0] rd_mux;

  assign wr_ready = (full_count < CNT_W'(NUM_BANKS));
  assign rd_avail = (full_count != '0);
  assign wr_fire  = wr_valid & wr_ready;
  assign tile_cmp = wr_fire & (wr_idx == IDX_W'(COL_X - 1));
  assign rel      = rd_release & rd_avail;
  assign re       = rd_en & rd_avail;

  // Bank-major addressing: each bank owns a contiguous COL_X-entry region.
  assign waddr = AW'(wr_bank) * AW'(COL_X) + AW'(wr_idx);
  assign raddr = AW'(rd_bank) * AW'(COL_X) + AW'(rd_idx);

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_ch
    logic [MODULE_WIDTH-1:0] wslice;
    assign wslice = MODULE_WIDTH'(extract_slice(MAX_W'(wr_data[gi]), IN_WIDTH, MODULE_WIDTH, SLICE_IDX));

    pp_sdp_ram #(
      .DATA_W (MODULE_WIDTH),
      .DEPTH  (DEPTH)
    ) u_ram (
      .clk   (clk),
      .we    (wr_fire),
      .waddr (waddr),
      .wdata (wslice),
      .re    (re),
      .raddr (raddr),
      .rdata (ram_q[gi])
    );
  end

  // Select the channel captured with the read; out-of-range selects return zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (sel_q == SEL_W'(i)) rd_mux = ram_q[i];
    end
  end

  // RAM output is not reset, so present zero until the first real read.
  assign rd_data = have_read ? rd_mux : '0;

  // Producer side: beat index, fill bank and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx       <= '0;
      wr_bank      <= '0;
      tile_done    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      tile_done <= tile_cmp;
      if (wr_valid && !wr_ready) overflow_err <= 1'b1;
      if (wr_fire) wr_idx <= tile_cmp ? '0 : wr_idx + 1'b1;
      if (tile_cmp) wr_bank <= BANK_W'(ring_inc(32'(wr_bank), NUM_BANKS));
    end
  end

  // Occupancy and read pointer; a completion and release in one cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_count <= '0;
      rd_bank    <= '0;
    end else begin
      case ({tile_cmp, rel})
        2'b10:   full_count <= full_count + 1'b1;
        2'b01:   full_count <= full_count - 1'b1;
        default: full_count <= full_count;
      endcase
      if (rel) rd_bank <= BANK_W'(ring_inc(32'(rd_bank), NUM_BANKS));
    end
  end

  // Read handshake: valid strobe and the channel select that travels with the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid  <= 1'b0;
      sel_q     <= '0;
      have_read <= 1'b0;
    end else begin
      rd_valid <= re;
      if (re) begin
        sel_q     <= rd_sel;
        have_read <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pingpong_tile_buffer.sv
// Directed bench for the tile buffer: two instances (2 banks/slice 0 and 3 banks/slice 1).
// Latency: reads are scored one cycle after issue by per-instance monitors.
// Backpressure: exercises full banks, dropped beats and simultaneous complete/release.
module tb_pingpong_tile_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: 2 banks, slice 0 (upper byte of each 16-bit word).
  logic        wv_a = 1'b0;
  logic [15:0] wd_a [2];
  logic        rden_a = 1'b0;
  logic [0:0]  rsel_a = '0;
  logic [1:0]  ridx_a = '0;
  logic        rrel_a = 1'b0;
  logic        wr_ready_a, rd_valid_a, rd_avail_a, tile_done_a, ovf_a;
  logic [7:0]  rd_data_a;
  logic [1:0]  full_a;
  logic [0:0]  wbank_a, rbank_a;

  // Instance B: 3 banks, slice 1 (lower byte).
  logic        wv_b = 1'b0;
  logic [15:0] wd_b [2];
  logic        rden_b = 1'b0;
  logic [0:0]  rsel_b = '0;
  logic [1:0]  ridx_b = '0;
  logic        rrel_b = 1'b0;
  logic        wr_ready_b, rd_valid_b, rd_avail_b, tile_done_b, ovf_b;
  logic [7:0]  rd_data_b;
  logic [1:0]  full_b;
  logic [1:0]  wbank_b, rbank_b;

  logic [7:0] qa [$];
  logic [7:0] qb [$];

  pingpong_tile_buffer #(
    .WIDTH(8), .CHUNK_SIZE(1), .NUM_CORES_A(1), .NUM_CORES_B(1), .TOTAL_MODULES(2),
    .SLICE_IDX(0), .NUM_INPUTS(2), .NUM_BANKS(2), .COL_X(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_valid(wv_a), .wr_ready(wr_ready_a), .wr_data(wd_a),
    .rd_en(rden_a), .rd_sel(rsel_a), .rd_idx(ridx_a), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .rd_avail(rd_avail_a), .rd_release(rrel_a),
    .full_count(full_a), .wr_bank(wbank_a), .rd_bank(rbank_a),
    .tile_done(tile_done_a), .overflow_err(ovf_a)
  );

  pingpong_tile_buffer #(
    .WIDTH(8), .CHUNK_SIZE(1), .NUM_CORES_A(1), .NUM_CORES_B(1), .TOTAL_MODULES(2),
    .SLICE_IDX(1), .NUM_INPUTS(2), .NUM_BANKS(3), .COL_X(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_valid(wv_b), .wr_ready(wr_ready_b), .wr_data(wd_b),
    .rd_en(rden_b), .rd_sel(rsel_b), .rd_idx(ridx_b), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .rd_avail(rd_avail_b), .rd_release(rrel_b),
    .full_count(full_b), .wr_bank(wbank_b), .rd_bank(rbank_b),
    .tile_done(tile_done_b), .overflow_err(ovf_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitors: every rd_valid must match the oldest outstanding expected read.
  always @(negedge clk) begin
    if (rd_valid_a) begin
      if (qa.size() == 0) chk("a_unexpected_rd_valid", 32'd1, 32'd0);
      else chk("a_rd_data", 32'(rd_data_a), 32'(qa.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rd_valid_b) begin
      if (qb.size() == 0) chk("b_unexpected_rd_valid", 32'd1, 32'd0);
      else chk("b_rd_data", 32'(rd_data_b), 32'(qb.pop_front()));
    end
  end

  // Stream cnt beats into A: ch0 upper byte base0+n, ch1 upper byte base1+n.
  task automatic beats_a(input logic [7:0] base0, input logic [7:0] base1, input int cnt);
    for (int n = 0; n < cnt; n++) begin
      @(negedge clk);
      wv_a = 1'b1;
      wd_a[0] = {8'(base0 + n), 8'h00};
      wd_a[1] = {8'(base1 + n), 8'h00};
    end
    @(negedge clk);
    wv_a = 1'b0;
  endtask

  // Stream cnt beats into B: ch0 lower byte base0+n, ch1 lower byte base1+n.
  task automatic beats_b(input logic [7:0] base0, input logic [7:0] base1, input int cnt);
    for (int n = 0; n < cnt; n++) begin
      @(negedge clk);
      wv_b = 1'b1;
      wd_b[0] = {8'hEE, 8'(base0 + n)};
      wd_b[1] = {8'hFF, 8'(base1 + n)};
    end
    @(negedge clk);
    wv_b = 1'b0;
  endtask

  task automatic rd_a(input logic sel, input logic [1:0] idx, input logic [7:0] exp);
    @(negedge clk);
    rden_a = 1'b1; rsel_a = sel; ridx_a = idx;
    qa.push_back(exp);
    @(negedge clk);
    rden_a = 1'b0;
  endtask

  task automatic rd_b(input logic sel, input logic [1:0] idx, input logic [7:0] exp);
    @(negedge clk);
    rden_b = 1'b1; rsel_b = sel; ridx_b = idx;
    qb.push_back(exp);
    @(negedge clk);
    rden_b = 1'b0;
  endtask

  task automatic rel_a();
    @(negedge clk);
    rrel_a = 1'b1;
    @(negedge clk);
    rrel_a = 1'b0;
  endtask

  task automatic rel_b();
    @(negedge clk);
    rrel_b = 1'b1;
    @(negedge clk);
    rrel_b = 1'b0;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_full"},   32'(full_a), 0);
    chk({tag, "_wbank"},  32'(wbank_a), 0);
    chk({tag, "_rbank"},  32'(rbank_a), 0);
    chk({tag, "_rvalid"}, 32'(rd_valid_a), 0);
    chk({tag, "_rdata"},  32'(rd_data_a), 0);
    chk({tag, "_tdone"},  32'(tile_done_a), 0);
    chk({tag, "_ovf"},    32'(ovf_a), 0);
    chk({tag, "_wready"}, 32'(wr_ready_a), 1);
    chk({tag, "_ravail"}, 32'(rd_avail_a), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wd_a[0] = '0; wd_a[1] = '0; wd_b[0] = '0; wd_b[1] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_a("rst");
    chk("rst_b_wready", 32'(wr_ready_b), 1);

    // Fill one tile, read it back.
    beats_a(8'hA0, 8'hC0, 4);
    chk("s1_tdone", 32'(tile_done_a), 1);
    chk("s1_full", 32'(full_a), 1);
    chk("s1_wbank", 32'(wbank_a), 1);
    chk("s1_ravail", 32'(rd_avail_a), 1);
    @(negedge clk);
    chk("s1_tdone_pulse", 32'(tile_done_a), 0);
    rd_a(1'b0, 2'd2, 8'hA2);
    rd_a(1'b1, 2'd0, 8'hC0);

    // Second tile fills both banks; a further beat is dropped.
    beats_a(8'hA4, 8'hC4, 4);
    chk("s3_full", 32'(full_a), 2);
    chk("s3_wready", 32'(wr_ready_a), 0);
    chk("s3_ovf_clear", 32'(ovf_a), 0);
    beats_a(8'hFF, 8'hFF, 1);
    chk("s3_ovf", 32'(ovf_a), 1);
    chk("s3_full_hold", 32'(full_a), 2);
    chk("s3_wbank_hold", 32'(wbank_a), 0);
    rd_a(1'b0, 2'd3, 8'hA3);
    rel_a();
    chk("s3_rel_full", 32'(full_a), 1);
    chk("s3_rel_wready", 32'(wr_ready_a), 1);
    chk("s3_rel_rbank", 32'(rbank_a), 1);
    rd_a(1'b0, 2'd1, 8'hA5);

    // Completion, release and read all in one cycle.
    beats_a(8'hB0, 8'hD0, 3);
    @(negedge clk);
    wv_a = 1'b1; wd_a[0] = {8'hB3, 8'h00}; wd_a[1] = {8'hD3, 8'h00};
    rrel_a = 1'b1; rden_a = 1'b1; rsel_a = 1'b0; ridx_a = 2'd2;
    qa.push_back(8'hA6);
    @(negedge clk);
    wv_a = 1'b0; rrel_a = 1'b0; rden_a = 1'b0;
    chk("s4_full", 32'(full_a), 1);
    chk("s4_wbank", 32'(wbank_a), 1);
    chk("s4_rbank", 32'(rbank_a), 0);
    chk("s4_tdone", 32'(tile_done_a), 1);
    chk("s4_ovf_sticky", 32'(ovf_a), 1);
    rd_a(1'b0, 2'd3, 8'hB3);
    rd_a(1'b0, 2'd0, 8'hB0);

    // Drain, then reads and releases on an empty buffer are ignored.
    rel_a();
    chk("s4_empty_full", 32'(full_a), 0);
    chk("s4_empty_rbank", 32'(rbank_a), 1);
    @(negedge clk);
    rden_a = 1'b1; ridx_a = 2'd1;
    @(negedge clk);
    rden_a = 1'b0;
    chk("ign_rvalid", 32'(rd_valid_a), 0);
    chk("ign_rdata_hold", 32'(rd_data_a), 32'hB0);
    rel_a();
    chk("ign_rel_rbank", 32'(rbank_a), 1);
    chk("ign_rel_full", 32'(full_a), 0);

    // Instance B: slice 1, channel 1 readback.
    beats_b(8'h50, 8'h30, 4);
    chk("s2_full", 32'(full_b), 1);
    chk("s2_tdone", 32'(tile_done_b), 1);
    rd_b(1'b1, 2'd3, 8'h33);
    rd_b(1'b0, 2'd1, 8'h51);

    // Three banks: producer runs ahead two more tiles before stalling.
    beats_b(8'h00, 8'h60, 4);
    chk("s5_full2", 32'(full_b), 2);
    chk("s5_wready2", 32'(wr_ready_b), 1);
    beats_b(8'h00, 8'h70, 4);
    chk("s5_full3", 32'(full_b), 3);
    chk("s5_wready3", 32'(wr_ready_b), 0);
    chk("s5_wbank", 32'(wbank_b), 0);
    chk("s5_ovf", 32'(ovf_b), 0);
    rel_b();
    chk("s5_rbank1", 32'(rbank_b), 1);
    rd_b(1'b1, 2'd0, 8'h60);
    rel_b();
    chk("s5_rbank2", 32'(rbank_b), 2);
    rd_b(1'b1, 2'd2, 8'h72);
    rel_b();
    chk("s5_rbank0", 32'(rbank_b), 0);
    chk("s5_full0", 32'(full_b), 0);
    chk("s5_ravail0", 32'(rd_avail_b), 0);

    // Reset mid-tile discards the partial tile.
    beats_a(8'h90, 8'h90, 2);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_a("mid_rst");
    rst_n = 1'b1;
    beats_a(8'hE0, 8'hF0, 4);
    chk("s6_full", 32'(full_a), 1);
    chk("s6_wbank", 32'(wbank_a), 1);
    chk("s6_rbank", 32'(rbank_a), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rden_a = 1'b1; rsel_a = 1'b0; ridx_a = 2'(i);
      qa.push_back(8'(8'hE0 + i));
    end
    @(negedge clk);
    rden_a = 1'b0;
    rd_a(1'b1, 2'd1, 8'hF1);

    repeat (3) @(negedge clk);
    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
